// File: rtl/dbg_state_reader.sv
// Snapshots the 4-deep debug-state history on request and shifts it out MSB first as a SYNC/payload/parity frame.
// First bit appears on the cycle after the accepting edge; no backpressure: requests outside IDLE are dropped.
module dbg_state_reader #(
  parameter int unsigned BIT_DIV = 4,
  parameter logic [3:0]  SYNC    = 4'b1010
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iRdReq,
  input  logic       iClrAfterRd,
  input  logic [3:0] iCurState,
  input  logic [3:0] iPrevState2,
  input  logic [3:0] iPrevState1,
  input  logic [3:0] iPrevState0,
  output logic       oBusy,
  output logic       oSerData,
  output logic       oSerValid,
  output logic       oFrameStart,
  output logic       oClearLog,
  output logic       oDone
);

  localparam logic [4:0] LAST_IDX = 5'd20;
  localparam logic [7:0] LAST_CNT = 8'(BIT_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CLEAR = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [4:0]  idx_q;
  logic [15:0] snap_q;
  logic        par_q;
  logic        clr_q;
  logic        busy_q;
  logic        ser_q;
  logic        vld_q;
  logic        fs_q;
  logic        clrlog_q;
  logic        done_q;

  logic [15:0] snap_d;
  logic        par_d;
  logic [4:0]  idx_d;
  logic        ser_d;
  logic        bit_end;
  logic [20:0] frame;

  assign snap_d  = {iCurState, iPrevState2, iPrevState1, iPrevState0};
  assign par_d   = ^snap_d;
  assign bit_end = (cnt_q == LAST_CNT);
  assign frame   = {SYNC, snap_q, par_q};
  assign idx_d   = idx_q + 5'd1;
  // Bit k of the frame lives at frame[20-k]; the guard only matters on the final bit.
  assign ser_d   = (idx_d <= LAST_IDX) ? frame[LAST_IDX - idx_d] : 1'b0;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      snap_q   <= '0;
      par_q    <= 1'b0;
      clr_q    <= 1'b0;
      busy_q   <= 1'b0;
      ser_q    <= 1'b0;
      vld_q    <= 1'b0;
      fs_q     <= 1'b0;
      clrlog_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      clrlog_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          cnt_q  <= '0;
          idx_q  <= '0;
          busy_q <= 1'b0;
          ser_q  <= 1'b0;
          vld_q  <= 1'b0;
          fs_q   <= 1'b0;
          if (iRdReq) begin
            snap_q  <= snap_d;
            par_q   <= par_d;
            clr_q   <= iClrAfterRd;
            busy_q  <= 1'b1;
            ser_q   <= SYNC[3];
            vld_q   <= 1'b1;
            fs_q    <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bit_end) begin
            cnt_q <= '0;
            fs_q  <= 1'b0;
            if (idx_q == LAST_IDX) begin
              idx_q <= '0;
              ser_q <= 1'b0;
              vld_q <= 1'b0;
              if (clr_q) begin
                clrlog_q <= 1'b1;
                state_q  <= S_CLEAR;
              end else begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
            end else begin
              idx_q <= idx_d;
              ser_q <= ser_d;
              vld_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
            vld_q <= 1'b0;
          end
        end
        S_CLEAR: begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oBusy       = busy_q;
  assign oSerData    = ser_q;
  assign oSerValid   = vld_q;
  assign oFrameStart = fs_q;
  assign oClearLog   = clrlog_q;
  assign oDone       = done_q;

endmodule
